bp_table_ctrl: RTL and testbench
================================

# bp_table_ctrl

Controller for the branch-prediction pattern table: owns 2^IDX_W two-bit saturating counters behind a single access port and arbitrates between fetch-side prediction lookups and execute-side training updates. Updates are buffered in a small FIFO so execute never loses a resolution; fetch sees a simple valid/ready lookup with a one-cycle result. After reset it sequences a table-initialisation sweep before accepting any traffic.

## Interface
- IDX_W, 6: table index width; table holds 2^IDX_W entries.
- UQ_DEPTH, 2: update FIFO depth; power of two, at least 2.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch lookup request.
- pred_idx  in  IDX_W  lookup index.
- pred_ready  out  1  lookup accepted this cycle when high with pred_valid.
- pred_out_valid  out  1  result valid; pulses one cycle after acceptance.
- pred_taken  out  1  prediction, bit 1 of the looked-up counter.
- upd_valid  in  1  execute training request.
- upd_idx  in  IDX_W  index to train.
- upd_actual  in  1  resolved outcome, 1 = taken.
- upd_ready  out  1  update accepted when high with upd_valid.
- init_busy  out  1  high during the initialisation sweep.

## Operation
- States: INIT, RUN.
- INIT: sweep pointer walks entries 0 to 2^IDX_W-1, one entry per cycle, writing 01 (weak not-taken). pred_ready = upd_ready = 0, init_busy = 1. After the last entry, move to RUN.
- RUN: at most one table access per cycle, either a predict read or an update read-modify-write. Priority:
  - FIFO count == UQ_DEPTH: drain an update.
  - Otherwise, pred_valid: serve the predict.
  - Otherwise, FIFO non-empty: drain an update.
- pred_ready = RUN and count < UQ_DEPTH. upd_ready = RUN and count < UQ_DEPTH.
- Enqueue and drain can occur in the same cycle; count is unchanged.
- Counter update on drain: 00→(1:01, 0:00); 01→(1:10, 0:00); 10→(1:11, 0:01); 11→(1:11, 0:10).
- A predict reads the table as it stands in the cycle of acceptance. Updates still queued in the FIFO are not visible to it.
- FIFO order is strict arrival order. Two queued updates to the same index both apply, in sequence.

## Timing
- Reset values: pred_ready 0, upd_ready 0, pred_out_valid 0, pred_taken 0, init_busy 1, FIFO empty, sweep pointer 0.
- Sweep length is 2^IDX_W cycles. With the default IDX_W, init_busy falls and the ready outputs rise on the 64th rising edge after rst deasserts.
- Predict latency is 1 cycle: pred_out_valid and pred_taken are registered. pred_taken holds its value until the next result.
- An update takes effect in the table on the edge of its drain cycle. A predict to that index accepted in the following cycle sees the new value.
- Worst-case predict stall is 1 cycle per full-FIFO drain.
- Reset asserted mid-operation: everything clears asynchronously, state returns to INIT, the FIFO empties, and an in-flight result is dropped (pred_out_valid 0).

## Configuration
- BP_GSHARE_EN defined: an IDX_W-bit global history register (reset 0) is added.
  - Predict index is pred_idx XOR GHR.
  - Drain index is upd_idx XOR GHR, using the GHR value before that drain.
  - On each drain, GHR shifts left and upd_actual enters at bit 0.
- BP_GSHARE_EN undefined: no GHR; indices are used directly.

## Test plan
- Release rst, hold pred_valid = 1 → pred_ready stays 0 for 64 cycles; then a lookup of idx 5 gives pred_taken = 0 one cycle later.
- Enqueue updates (idx 3, taken) twice, then predict idx 3 → pred_taken = 1 (counter 11). One not-taken update → counter 10, still predicts 1.
- Hold pred_valid every cycle while issuing 2 updates → the FIFO fills, the next cycle drains with pred_ready = 0, and predicts resume the following cycle.
- Enqueue in the same cycle as a drain at count 1 → count stays 1 and no update is lost; verify final counters against a reference model.
- Assert rst while the FIFO holds 2 entries → after the re-sweep, every entry reads 01 (pred_taken 0).
- With BP_GSHARE_EN: one taken update at idx 0 (GHR 0 → 1), then predict idx 1 → reads entry 0 = 10, so pred_taken = 1.

Source files
------------

// File: rtl/bp_table_ctrl_if.sv
// Fetch/execute access bundle for the branch-prediction pattern table.
// The controller uses the slave modport; the fetch/execute side uses master.
interface bp_table_ctrl_if #(
  parameter int IDX_W = 6
);
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_ready;
  logic             pred_out_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_actual;
  logic             upd_ready;

  modport master (
    output pred_valid, pred_idx, upd_valid, upd_idx, upd_actual,
    input  pred_ready, pred_out_valid, pred_taken, upd_ready
  );

  modport slave (
    input  pred_valid, pred_idx, upd_valid, upd_idx, upd_actual,
    output pred_ready, pred_out_valid, pred_taken, upd_ready
  );
endinterface

// File: rtl/bp_table_ctrl.sv
// Branch-prediction pattern table controller: 2^IDX_W two-bit saturating
// counters behind one access port. Predict lookups and buffered training
// updates share the port; a full update queue forces a drain ahead of fetch.
// After reset, a sweep writes every entry to weak not-taken before traffic.
// Optional feature macro: BP_GSHARE_EN (XOR indices with a global history).
module bp_table_ctrl #(
  parameter int IDX_W    = 6,
  parameter int UQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active low
  bp_table_ctrl_if.slave    bus,
  output logic              init_busy
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(UQ_DEPTH);
  localparam int CNT_W   = $clog2(UQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UQ_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] sweep_ptr_reg;
  logic [1:0]       table_mem [ENTRIES];

  // Update queue: storage plus pointers; depth is a power of two so the
  // pointers wrap naturally.
  logic [IDX_W-1:0] uq_idx_mem [UQ_DEPTH];
  logic             uq_act_mem [UQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic             pred_out_valid_reg, pred_taken_reg;
  logic             fifo_full, sweep_wr, drain, pred_fire, enq, tbl_we;
  logic [IDX_W-1:0] head_idx, pred_addr, drain_addr, tbl_waddr;
  logic             head_act;
  logic [1:0]       tbl_wdata;

  // Saturating two-bit counter step toward the resolved outcome.
  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign fifo_full = (count_reg == FULL_CNT);
  assign head_idx  = uq_idx_mem[rd_ptr_reg];
  assign head_act  = uq_act_mem[rd_ptr_reg];
  assign pred_fire = bus.pred_valid && bus.pred_ready;
  assign enq       = bus.upd_valid && bus.upd_ready;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_reg;
  assign pred_addr  = bus.pred_idx ^ ghr_reg;
  assign drain_addr = head_idx ^ ghr_reg;

  // Global history: each drained outcome shifts in at bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ghr_reg <= '0;
    else if (drain) ghr_reg <= {ghr_reg[IDX_W-2:0], head_act};
  end
`else
  assign pred_addr  = bus.pred_idx;
  assign drain_addr = head_idx;
`endif

  // State register and sweep pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_INIT;
      sweep_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (sweep_wr) sweep_ptr_reg <= sweep_ptr_reg + 1'b1;
    end
  end

  // Next state and per-cycle access arbitration: full queue drains first,
  // then fetch, then any leftover queued update.
  always_comb begin
    state_next     = state_reg;
    init_busy      = 1'b0;
    bus.pred_ready = 1'b0;
    bus.upd_ready  = 1'b0;
    sweep_wr       = 1'b0;
    drain          = 1'b0;
    unique case (state_reg)
      S_INIT: begin
        init_busy = 1'b1;
        sweep_wr  = 1'b1;
        if (&sweep_ptr_reg) state_next = S_RUN;
      end
      S_RUN: begin
        bus.pred_ready = !fifo_full;
        bus.upd_ready  = !fifo_full;
        drain          = fifo_full || (!bus.pred_valid && (count_reg != '0));
      end
      default: state_next = S_INIT;
    endcase
  end

  assign tbl_we    = sweep_wr || drain;
  assign tbl_waddr = sweep_wr ? sweep_ptr_reg : drain_addr;
  assign tbl_wdata = sweep_wr ? 2'b01 : sat_next(table_mem[drain_addr], head_act);

  // Table write port: sweep initialisation or drain read-modify-write.
  always_ff @(posedge clk) begin
    if (tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
  end

  // Queue storage write on enqueue.
  always_ff @(posedge clk) begin
    if (enq) begin
      uq_idx_mem[wr_ptr_reg] <= bus.upd_idx;
      uq_act_mem[wr_ptr_reg] <= bus.upd_actual;
    end
  end

  // Queue pointers and occupancy; simultaneous enqueue and drain cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (drain) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({enq, drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered predict result; the taken bit holds until the next result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_out_valid_reg <= 1'b0;
      pred_taken_reg     <= 1'b0;
    end else begin
      pred_out_valid_reg <= pred_fire;
      if (pred_fire) pred_taken_reg <= table_mem[pred_addr][1];
    end
  end

  assign bus.pred_out_valid = pred_out_valid_reg;
  assign bus.pred_taken     = pred_taken_reg;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl: reset/sweep timing, a table of per-cycle
// vectors, a reference-model stress of the update queue, and mid-run reset.
module tb_bp_table_ctrl;
  localparam int IDX_W   = 6;
  localparam int ENTRIES = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;
  logic init_busy;

  always #5 clk = ~clk;

  bp_table_ctrl_if #(.IDX_W(IDX_W)) bus ();

  bp_table_ctrl #(.IDX_W(IDX_W), .UQ_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_busy (init_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] model [ENTRIES];

  typedef struct {
    logic       pv;
    logic [5:0] pidx;
    logic       uv;
    logic [5:0] uidx;
    logic       ua;
    logic       pr;   // expected pred_ready during the cycle
    logic       ur;   // expected upd_ready during the cycle
    logic       ov;   // expected pred_out_valid after the edge
    logic       tk;   // expected pred_taken after the edge
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mkv(input logic pv, input int pidx, input logic uv, input int uidx,
                               input logic ua, input logic pr, input logic ur,
                               input logic ov, input logic tk);
    vec_t v;
    v.pv = pv; v.pidx = 6'(pidx); v.uv = uv; v.uidx = 6'(uidx); v.ua = ua;
    v.pr = pr; v.ur = ur; v.ov = ov; v.tk = tk;
    return v;
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    case ({c, t})
      3'b000: return 2'b00;  3'b001: return 2'b01;
      3'b010: return 2'b00;  3'b011: return 2'b10;
      3'b100: return 2'b01;  3'b101: return 2'b11;
      3'b110: return 2'b10;  default: return 2'b11;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic idle_inputs();
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    bus.upd_actual = 1'b0;
    bus.upd_idx    = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model[i] = 2'b01;
  endtask

  // Called just after an edge with rst already released; counts edges until
  // init_busy falls and confirms no ready was offered during the sweep.
  task automatic wait_init(input string tag);
    int n = 0;
    int bad = 0;
    while (init_busy && n < 200) begin
      if (bus.pred_ready || bus.upd_ready) bad++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_sweep_edges"}, n, 64);
    check({tag, "_ready_during_init"}, bad, 0);
    check({tag, "_ready_after_init"}, {bus.pred_ready, bus.upd_ready}, 2'b11);
  endtask

  task automatic readback_all(input string tag);
    for (int i = 0; i < ENTRIES; i++) begin
      bus.pred_valid = 1'b1;
      bus.pred_idx   = 6'(i);
      @(posedge clk); #1;
      check($sformatf("%s_idx%0d", tag, i), {bus.pred_out_valid, bus.pred_taken},
            {1'b1, model[i][1]});
    end
    bus.pred_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    bus.pred_idx = 6'd5;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pred_ready", bus.pred_ready, 0);
    check("rst_upd_ready", bus.upd_ready, 0);
    check("rst_out_valid", bus.pred_out_valid, 0);
    check("rst_taken", bus.pred_taken, 0);
    check("rst_init_busy", init_busy, 1);

    // Hold a lookup of idx 5 through the sweep; it is served right after.
    bus.pred_valid = 1'b1;
    rst = 1'b1;
    wait_init("init");
    @(posedge clk); #1;
    check("first_lookup_idx5", {bus.pred_out_valid, bus.pred_taken}, 2'b10);
    bus.pred_valid = 1'b0;

`ifdef BP_GSHARE_EN
    // Taken update at idx 0 with GHR 0, then predict idx 1 -> entry 0.
    bus.upd_valid = 1'b1; bus.upd_idx = 6'd0; bus.upd_actual = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    bus.pred_valid = 1'b1; bus.pred_idx = 6'd1;
    @(posedge clk); #1;
    check("gshare_idx1_hits_entry0", {bus.pred_out_valid, bus.pred_taken}, 2'b11);
    bus.pred_idx = 6'd0;
    @(posedge clk); #1;
    check("gshare_idx0_hits_entry1", {bus.pred_out_valid, bus.pred_taken}, 2'b10);
    bus.pred_valid = 1'b0;
`else
    //               pv pidx uv uidx ua  pr ur ov tk
    vecs[0]  = mkv(0, 0, 1, 3, 1,  1, 1, 0, 0);  // enqueue (3,T), count 1
    vecs[1]  = mkv(0, 0, 1, 3, 1,  1, 1, 0, 0);  // enqueue + drain, count 1, c3=10
    vecs[2]  = mkv(0, 0, 0, 0, 0,  1, 1, 0, 0);  // drain, c3=11
    vecs[3]  = mkv(1, 3, 0, 0, 0,  1, 1, 1, 1);  // predict 3 -> 1
    vecs[4]  = mkv(0, 0, 1, 3, 0,  1, 1, 0, 1);  // enqueue (3,N)
    vecs[5]  = mkv(0, 0, 0, 0, 0,  1, 1, 0, 1);  // drain, c3=10
    vecs[6]  = mkv(1, 3, 0, 0, 0,  1, 1, 1, 1);  // predict 3 -> still 1
    vecs[7]  = mkv(1, 7, 1, 9, 1,  1, 1, 1, 0);  // predict wins, count 1
    vecs[8]  = mkv(1, 7, 1, 9, 1,  1, 1, 1, 0);  // predict wins, count 2
    vecs[9]  = mkv(1, 7, 0, 0, 0,  0, 0, 0, 0);  // full: stall, drain c9=10
    vecs[10] = mkv(1, 9, 0, 0, 0,  1, 1, 1, 1);  // sees drained value
    vecs[11] = mkv(1, 9, 0, 0, 0,  1, 1, 1, 1);
    vecs[12] = mkv(0, 0, 0, 0, 0,  1, 1, 0, 1);  // drain c9=11
    vecs[13] = mkv(1, 9, 0, 0, 0,  1, 1, 1, 1);
    for (int i = 0; i < 14; i++) begin
      bus.pred_valid = vecs[i].pv;  bus.pred_idx   = vecs[i].pidx;
      bus.upd_valid  = vecs[i].uv;  bus.upd_idx    = vecs[i].uidx;
      bus.upd_actual = vecs[i].ua;
      #2;
      check($sformatf("vec%0d_ready", i), {bus.pred_ready, bus.upd_ready}, {vecs[i].pr, vecs[i].ur});
      if (vecs[i].uv && vecs[i].ur) model[vecs[i].uidx] = sat(model[vecs[i].uidx], vecs[i].ua);
      @(posedge clk); #1;
      check($sformatf("vec%0d_result", i), {bus.pred_out_valid, bus.pred_taken}, {vecs[i].ov, vecs[i].tk});
    end
    idle_inputs();

    // Back-to-back updates (enqueue while draining at count 1) over a few
    // indices with repeats; final counters compared with the model.
    for (int k = 0; k < 40; k++) begin
      bus.upd_valid  = 1'b1;
      bus.upd_idx    = 6'(((k * 5 + 2) % 8) + 16);
      bus.upd_actual = ((k * k + k / 3) % 3) != 0;
      #2;
      check($sformatf("stress%0d_upd_ready", k), bus.upd_ready, 1);
      model[bus.upd_idx] = sat(model[bus.upd_idx], bus.upd_actual);
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (4) @(posedge clk);
    #1;
    readback_all("model");
`endif

    // Fill the queue behind a stream of predicts, then reset mid-run.
    idle_inputs();
    bus.pred_valid = 1'b1; bus.pred_idx = 6'd0;
    bus.upd_valid  = 1'b1; bus.upd_idx  = 6'd20; bus.upd_actual = 1'b1;
    @(posedge clk); #1;
    bus.upd_idx = 6'd21;
    @(posedge clk); #1;
    idle_inputs();
    check("pre_reset_out_valid", bus.pred_out_valid, 1);
    check("pre_reset_queue_full", bus.upd_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_valid", bus.pred_out_valid, 0);
    check("async_rst_init_busy", init_busy, 1);
    check("async_rst_ready", {bus.pred_ready, bus.upd_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_init("reinit");
    repeat (4) @(posedge clk);
    #1;
    model_reset();
    readback_all("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
